// File: rtl/dtw_ref_stream_mem_if.sv
// Port bundle for the double-buffered DTW reference memory.
// Both load and read sides use valid/ready: a beat transfers on a rising clk edge where
// valid && ready are both high; the source holds its payload stable until that edge.
interface dtw_ref_stream_mem_if #(
  parameter int WIDTH   = 16,
  parameter int PTR_WID = 15
);
  logic               ld_valid;
  logic [WIDTH-1:0]   ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               swap;
  logic               start;
  logic               loop_en;
  logic               stop;
  logic               rd_valid;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_last;
  logic               rd_ready;
  logic               busy;
  logic [PTR_WID:0]   active_len;
  logic [PTR_WID:0]   shadow_len;
  logic               shadow_done;
  logic               err;
  logic [1:0]         dbg_state;

  modport master (
    output ld_valid, ld_data, ld_last, swap, start, loop_en, stop, rd_ready,
    input  ld_ready, rd_valid, rd_data, rd_last, busy, active_len, shadow_len,
           shadow_done, err, dbg_state
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, swap, start, loop_en, stop, rd_ready,
    output ld_ready, rd_valid, rd_data, rd_last, busy, active_len, shadow_len,
           shadow_done, err, dbg_state
  );
endinterface

// File: rtl/dtw_ref_stream_mem.sv
// Double-buffered reference sample store: load fills the shadow bank while the
// streamer plays the active bank through a 2-entry output FIFO.
module dtw_ref_stream_mem #(
  parameter int WIDTH   = 16,
  parameter int PTR_WID = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  dtw_ref_stream_mem_if.slave  bus
);
  localparam int DEPTH = 2 ** PTR_WID;
  localparam logic [PTR_WID:0] DEPTH_LEN = (PTR_WID+1)'(DEPTH);
  localparam logic [PTR_WID:0] LEN_ONE   = (PTR_WID+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic                 bank_sel;
  logic [PTR_WID:0]     active_len;
  logic [PTR_WID:0]     shadow_len;
  logic                 shadow_done;
  logic [PTR_WID-1:0]   rd_addr;
  logic                 loop_q;
  logic                 err_q;

  logic [WIDTH-1:0]     mem0 [DEPTH];
  logic [WIDTH-1:0]     mem1 [DEPTH];
  logic [WIDTH-1:0]     mem0_q;
  logic [WIDTH-1:0]     mem1_q;
  logic [WIDTH-1:0]     mem_q;

  logic                 inflight;
  logic                 inflight_last;
  logic [WIDTH-1:0]     fifo_data [2];
  logic                 fifo_last [2];
  logic                 fifo_wr;
  logic                 fifo_rd;
  logic [1:0]           fifo_cnt;

  logic                 ld_xfer;
  logic                 swap_ok;
  logic                 start_ok;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic                 issue_last;
  logic [2:0]           occ;
  logic [PTR_WID:0]     shadow_len_inc;

  assign ld_xfer        = bus.ld_valid && !shadow_done;
  assign swap_ok        = bus.swap && shadow_done && (state == S_IDLE);
  assign start_ok       = bus.start && (state == S_IDLE) && (active_len != '0) && !swap_ok;
  assign push           = inflight;
  assign pop            = (fifo_cnt != 2'd0) && bus.rd_ready;
  // Occupancy after this edge if no new read were issued; a read is only issued
  // when its data is guaranteed a FIFO slot two edges later.
  assign occ            = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue          = (state == S_RUN) && (occ < 3'd2);
  assign issue_last     = ({1'b0, rd_addr} == (active_len - LEN_ONE));
  assign shadow_len_inc = shadow_len + LEN_ONE;
  assign mem_q          = bank_sel ? mem1_q : mem0_q;

  // Shadow bank is !bank_sel; swaps only happen in IDLE so a bank never sees
  // a write and a stream read at the same time.
  always_ff @(posedge clk) begin
    if (ld_xfer && bank_sel)
      mem0[shadow_len[PTR_WID-1:0]] <= bus.ld_data;
    if (issue)
      mem0_q <= mem0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (ld_xfer && !bank_sel)
      mem1[shadow_len[PTR_WID-1:0]] <= bus.ld_data;
    if (issue)
      mem1_q <= mem1[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bank_sel      <= 1'b0;
      active_len    <= '0;
      shadow_len    <= '0;
      shadow_done   <= 1'b0;
      rd_addr       <= '0;
      loop_q        <= 1'b0;
      err_q         <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last[0]  <= 1'b0;
      fifo_last[1]  <= 1'b0;
      fifo_wr       <= 1'b0;
      fifo_rd       <= 1'b0;
      fifo_cnt      <= 2'd0;
    end else begin
      err_q <= (bus.swap && !swap_ok) || (bus.start && !start_ok);

      if (swap_ok) begin
        bank_sel    <= !bank_sel;
        active_len  <= shadow_len;
        shadow_len  <= '0;
        shadow_done <= 1'b0;
      end else if (ld_xfer) begin
        shadow_len <= shadow_len_inc;
        if (bus.ld_last || (shadow_len_inc == DEPTH_LEN))
          shadow_done <= 1'b1;
      end

      inflight      <= issue;
      inflight_last <= issue && issue_last;

      if (push) begin
        fifo_data[fifo_wr] <= mem_q;
        fifo_last[fifo_wr] <= inflight_last;
        fifo_wr            <= !fifo_wr;
      end
      if (pop)
        fifo_rd <= !fifo_rd;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state   <= S_RUN;
            loop_q  <= bus.loop_en;
            rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state <= S_IDLE;
          end else if (issue) begin
            if (issue_last) begin
              rd_addr <= '0;
              if (!loop_q)
                state <= S_DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.stop)
            state <= S_IDLE;
          else if (!inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Abort drops everything queued or still coming out of the RAM.
      if (bus.stop && (state != S_IDLE)) begin
        inflight <= 1'b0;
        fifo_cnt <= 2'd0;
        fifo_wr  <= 1'b0;
        fifo_rd  <= 1'b0;
      end
    end
  end

  assign bus.ld_ready    = !shadow_done;
  assign bus.rd_valid    = (fifo_cnt != 2'd0);
  assign bus.rd_data     = fifo_data[fifo_rd];
  assign bus.rd_last     = (fifo_cnt != 2'd0) && fifo_last[fifo_rd];
  assign bus.busy        = (state != S_IDLE);
  assign bus.active_len  = active_len;
  assign bus.shadow_len  = shadow_len;
  assign bus.shadow_done = shadow_done;
  assign bus.err         = err_q;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_dtw_ref_stream_mem.sv
// Directed bench for dtw_ref_stream_mem: stimulus pushes expected samples into a
// queue and a negedge monitor pops and compares every accepted output beat.
module tb_dtw_ref_stream_mem;
  localparam int WIDTH   = 16;
  localparam int PTR_WID = 3;
  localparam int W       = WIDTH + 1;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic         held_v;
  logic [W-1:0] held_d;

  dtw_ref_stream_mem_if #(.WIDTH(WIDTH), .PTR_WID(PTR_WID)) dif ();

  dtw_ref_stream_mem #(.WIDTH(WIDTH), .PTR_WID(PTR_WID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic push_exp(input logic last, input logic [WIDTH-1:0] data);
    exp_q.push_back({last, data});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("rd_hold_valid", 32'(dif.rd_valid), 32'd1);
          check("rd_hold_data", 32'({dif.rd_last, dif.rd_data}), 32'(held_d));
        end
        if (dif.rd_valid && dif.rd_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: got %0h required no output", {dif.rd_last, dif.rd_data});
          end else begin
            check("rd_sample", 32'({dif.rd_last, dif.rd_data}), 32'(exp_q.pop_front()));
          end
        end
        held_v = dif.rd_valid && !dif.rd_ready && !dif.stop;
        held_d = {dif.rd_last, dif.rd_data};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(input logic [WIDTH-1:0] data, input logic last);
    dif.ld_valid = 1'b1;
    dif.ld_data  = data;
    dif.ld_last  = last;
    tick();
    dif.ld_valid = 1'b0;
    dif.ld_last  = 1'b0;
  endtask

  task automatic pulse_swap();
    dif.swap = 1'b1;
    tick();
    dif.swap = 1'b0;
  endtask

  task automatic pulse_start(input logic loop);
    dif.start   = 1'b1;
    dif.loop_en = loop;
    tick();
    dif.start   = 1'b0;
    dif.loop_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || dif.busy) && t < budget) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0 || dif.busy) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d samples pending, busy=%0d required 0 and 0",
               name, exp_q.size(), dif.busy);
      exp_q.delete();
    end
  endtask

  task automatic push_ramp();
    push_exp(1'b0, 16'd10);
    push_exp(1'b0, 16'd20);
    push_exp(1'b0, 16'd30);
    push_exp(1'b0, 16'd40);
    push_exp(1'b1, 16'd50);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic bp_pat [4];
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;

    rst_n        = 1'b0;
    dif.ld_valid = 1'b0;
    dif.ld_data  = '0;
    dif.ld_last  = 1'b0;
    dif.swap     = 1'b0;
    dif.start    = 1'b0;
    dif.loop_en  = 1'b0;
    dif.stop     = 1'b0;
    dif.rd_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check("rst_rd_valid", 32'(dif.rd_valid), 32'd0);
    check("rst_rd_data", 32'(dif.rd_data), 32'd0);
    check("rst_rd_last", 32'(dif.rd_last), 32'd0);
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_ld_ready", 32'(dif.ld_ready), 32'd1);
    check("rst_active_len", 32'(dif.active_len), 32'd0);
    check("rst_shadow_len", 32'(dif.shadow_len), 32'd0);
    check("rst_shadow_done", 32'(dif.shadow_done), 32'd0);
    check("rst_err", 32'(dif.err), 32'd0);
    check("rst_state", 32'(dif.dbg_state), 32'd0);

    // start with an empty active bank is rejected
    pulse_start(1'b0);
    check("empty_start_err", 32'(dif.err), 32'd1);
    check("empty_start_busy", 32'(dif.busy), 32'd0);
    tick();
    check("err_one_cycle", 32'(dif.err), 32'd0);

    // load then stream
    load_one(16'd10, 1'b0);
    load_one(16'd20, 1'b0);
    load_one(16'd30, 1'b0);
    load_one(16'd40, 1'b0);
    load_one(16'd50, 1'b1);
    check("load_shadow_len", 32'(dif.shadow_len), 32'd5);
    check("load_shadow_done", 32'(dif.shadow_done), 32'd1);
    check("load_ld_ready", 32'(dif.ld_ready), 32'd0);
    pulse_swap();
    check("swap_active_len", 32'(dif.active_len), 32'd5);
    check("swap_shadow_len", 32'(dif.shadow_len), 32'd0);
    check("swap_ld_ready", 32'(dif.ld_ready), 32'd1);
    check("swap_err", 32'(dif.err), 32'd0);

    push_ramp();
    pulse_start(1'b0);
    check("lat_valid_n0", 32'(dif.rd_valid), 32'd0);
    check("run_state", 32'(dif.dbg_state), 32'd1);
    tick();
    check("lat_valid_n1", 32'(dif.rd_valid), 32'd0);
    tick();
    check("lat_valid_n2", 32'(dif.rd_valid), 32'd1);
    repeat (4) tick();
    check("last_sample_last", 32'(dif.rd_last), 32'd1);
    check("last_sample_busy", 32'(dif.busy), 32'd1);
    tick();
    check("done_busy", 32'(dif.busy), 32'd0);
    check("done_rd_valid", 32'(dif.rd_valid), 32'd0);
    check("done_queue_empty", 32'(exp_q.size()), 32'd0);

    // backpressure with rd_ready cycling 1,0,0,1
    push_ramp();
    pulse_start(1'b0);
    for (int i = 0; i < 80 && (exp_q.size() != 0 || dif.busy); i++) begin
      dif.rd_ready = bp_pat[i % 4];
      tick();
    end
    dif.rd_ready = 1'b1;
    wait_drain("bp", 40);

    // load the shadow bank while the active bank is streaming (held stalled)
    push_ramp();
    dif.rd_ready = 1'b0;
    pulse_start(1'b0);
    load_one(16'd100, 1'b0);
    load_one(16'd101, 1'b0);
    load_one(16'd102, 1'b0);
    load_one(16'd103, 1'b1);
    check("ovl_busy", 32'(dif.busy), 32'd1);
    check("ovl_shadow_len", 32'(dif.shadow_len), 32'd4);
    check("ovl_shadow_done", 32'(dif.shadow_done), 32'd1);
    pulse_swap();
    check("ovl_swap_err", 32'(dif.err), 32'd1);
    check("ovl_swap_active_len", 32'(dif.active_len), 32'd5);
    check("ovl_swap_shadow_len", 32'(dif.shadow_len), 32'd4);
    dif.rd_ready = 1'b1;
    wait_drain("ovl_stream", 40);
    pulse_swap();
    check("idle_swap_err", 32'(dif.err), 32'd0);
    check("idle_swap_active_len", 32'(dif.active_len), 32'd4);
    push_exp(1'b0, 16'd100);
    push_exp(1'b0, 16'd101);
    push_exp(1'b0, 16'd102);
    push_exp(1'b1, 16'd103);
    pulse_start(1'b0);
    wait_drain("ovl_new_bank", 40);

    // simultaneous swap+start: swap wins, start rejected
    load_one(16'd7, 1'b0);
    load_one(16'd8, 1'b0);
    load_one(16'd9, 1'b1);
    dif.swap  = 1'b1;
    dif.start = 1'b1;
    tick();
    dif.swap  = 1'b0;
    dif.start = 1'b0;
    check("swst_err", 32'(dif.err), 32'd1);
    check("swst_active_len", 32'(dif.active_len), 32'd3);
    check("swst_busy", 32'(dif.busy), 32'd0);

    // looped playback then stop
    for (int i = 0; i < 7; i++)
      push_exp((i % 3) == 2, WIDTH'(7 + (i % 3)));
    pulse_start(1'b1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      check("loop_no_bubble", 32'(dif.rd_valid), 32'd1);
      tick();
    end
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    check("loop_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    dif.rd_ready = 1'b0;
    dif.stop     = 1'b1;
    tick();
    dif.stop     = 1'b0;
    check("stop_rd_valid", 32'(dif.rd_valid), 32'd0);
    check("stop_busy", 32'(dif.busy), 32'd0);
    check("stop_err", 32'(dif.err), 32'd0);
    dif.rd_ready = 1'b1;
    dif.stop     = 1'b1;
    tick();
    dif.stop     = 1'b0;
    check("idle_stop_err", 32'(dif.err), 32'd0);

    // depth boundary: 9 offers without ld_last, only 8 fit
    for (int i = 0; i < 9; i++) load_one(WIDTH'(200 + i), 1'b0);
    check("full_shadow_len", 32'(dif.shadow_len), 32'd8);
    check("full_ld_ready", 32'(dif.ld_ready), 32'd0);
    check("full_shadow_done", 32'(dif.shadow_done), 32'd1);
    pulse_swap();
    check("full_swap_active_len", 32'(dif.active_len), 32'd8);
    for (int i = 0; i < 8; i++) push_exp(i == 7, WIDTH'(200 + i));
    pulse_start(1'b0);
    wait_drain("full_stream", 40);

    // asynchronous reset while streaming (output held stalled)
    dif.rd_ready = 1'b0;
    pulse_start(1'b1);
    repeat (3) tick();
    check("pre_rst_valid", 32'(dif.rd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_valid", 32'(dif.rd_valid), 32'd0);
    check("arst_rd_data", 32'(dif.rd_data), 32'd0);
    check("arst_busy", 32'(dif.busy), 32'd0);
    check("arst_active_len", 32'(dif.active_len), 32'd0);
    check("arst_ld_ready", 32'(dif.ld_ready), 32'd1);
    tick();
    rst_n        = 1'b1;
    dif.rd_ready = 1'b1;
    tick();
    pulse_start(1'b0);
    check("post_rst_start_err", 32'(dif.err), 32'd1);
    check("post_rst_busy", 32'(dif.busy), 32'd0);

    repeat (4) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dtw_ref_stream_mem.md
# dtw_ref_stream_mem

Double-buffered reference-sample memory for the DTW core. A load port fills a shadow bank while a streaming engine plays the active bank to the DTW datapath with valid/ready flow control. A swap command exchanges the banks, so a new reference can be loaded without stalling the current alignment. Single-pass and looped playback are both supported.

## Interface
- WIDTH, 16, sample width in bits
- PTR_WID, 15, address width per bank
- DEPTH, 2**PTR_WID, samples per bank
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_valid  in  1  load sample valid
- ld_data  in  WIDTH  load sample
- ld_last  in  1  final sample of this load
- ld_ready  out  1  shadow bank accepts a sample
- swap  in  1  pulse: exchange active and shadow banks
- start  in  1  pulse: begin streaming the active bank
- loop_en  in  1  sampled on an accepted start; 1 = wrap to address 0 after the last sample
- stop  in  1  pulse: abort streaming
- rd_valid  out  1  output sample valid
- rd_data  out  WIDTH  output sample
- rd_last  out  1  sample is at address active_len-1
- rd_ready  in  1  consumer accepts the sample
- busy  out  1  streamer not IDLE
- active_len  out  PTR_WID+1  sample count of the active bank
- shadow_len  out  PTR_WID+1  samples written to the shadow bank so far
- shadow_done  out  1  shadow load complete
- err  out  1  one-cycle pulse when a command is rejected

## Operation
- **Storage**
  - Two arrays of DEPTH×WIDTH, block RAM style, with a registered read.
  - Arrays are never reset.
  - bank_sel selects the active bank; the shadow bank is !bank_sel.
- **Load**
  - ld_ready = !shadow_done.
  - A transfer is ld_valid && ld_ready. It writes ld_data at shadow address shadow_len, then increments shadow_len.
  - shadow_done sets on a transfer with ld_last, or on the transfer that makes shadow_len == DEPTH.
  - Loading is independent of streaming state.
- **Swap**
  - Accepted only when shadow_done && state == IDLE.
  - On acceptance: toggle bank_sel, active_len <= shadow_len, shadow_len <= 0, shadow_done <= 0.
  - Otherwise the swap is ignored and err pulses.
- **Streamer FSM**
  - IDLE → RUN on start when active_len != 0 and no swap is accepted in the same cycle. Capture loop_en and set the read address to 0.
  - In all other cases start is ignored and err pulses. Swap has priority: on a simultaneous swap+start, the swap is accepted and the start is rejected.
  - RUN: issue one read per cycle while the output buffer has room; increment the address.
  - On issuing address active_len-1:
    - loop mode: the address wraps to 0 and the FSM stays in RUN;
    - otherwise: RUN → DRAIN.
  - DRAIN → IDLE when no reads are in flight and the output buffer is empty.
  - stop in RUN or DRAIN → IDLE next cycle. Discard in-flight and buffered samples; rd_valid = 0 from the next cycle. stop in IDLE has no effect and no err.
  - start while in RUN or DRAIN is ignored, err pulses.
- **Output buffer**
  - 2-entry FIFO in front of rd_*.
  - The read-issue condition guarantees no overflow: occupancy + in-flight reads − pop ≤ 2.
  - rd_data and rd_last stay stable while rd_valid && !rd_ready.
- **Reset (also mid-operation)**
  - state = IDLE, bank_sel = 0, active_len = 0, shadow_len = 0, shadow_done = 0.
  - rd_valid = 0, rd_last = 0, rd_data = 0, err = 0, busy = 0, ld_ready = 1.

## Timing
- Load write: a transfer on edge N is readable from the shadow bank after edge N+1.
- Swap: accepted on edge N. active_len, shadow_len and ld_ready update on edge N.
- Start latency: start accepted on edge N. Address 0 is issued in cycle N+1, and rd_valid rises after edge N+2.
- Throughput: with rd_ready held high, one sample per cycle with no bubbles, including across loop wrap.
- Backpressure: rd_ready low for K cycles causes no sample loss or duplication. Streaming resumes at 1 sample/cycle one cycle after rd_ready returns.
- Completion: single pass, rd_ready high. The last sample is at edge N+1+active_len and busy falls one cycle later.
- err: registered, high exactly the cycle after the rejected command.

## Test plan
- **Load then stream:** load 5 samples (10,20,30,40,50, ld_last on 50), swap, then start with loop_en=0 and rd_ready=1.
  - Expect shadow_len=5 and shadow_done=1 before the swap.
  - After start: rd_data 10..50 on consecutive cycles, first valid 2 cycles after start, rd_last only with 50, then busy=0.
- **Backpressure:** same stream with rd_ready toggling 1,0,0,1 repeatedly → exact sequence 10..50 with no loss or duplicates; rd_data holds while stalled.
- **Loop and stop:** loop_en=1, 3 samples (7,8,9) → output 7,8,9,7,8,9,… with rd_last on each 9. stop → rd_valid=0 next cycle, busy=0.
- **Overlap load:** while streaming bank 0, load 4 samples into bank 1.
  - Stream output is unaffected.
  - swap during RUN → err pulse, bank unchanged.
  - swap after IDLE → active_len=4.
- **Rejects and boundaries:**
  - start with active_len=0 → err.
  - Simultaneous swap+start → swap taken, err.
  - With PTR_WID=3, load 9 samples without ld_last → 8 accepted, ld_ready=0, shadow_done=1.
- **Async reset mid-stream:** assert rst_n=0 between edges → outputs reach reset values immediately; after release, start is rejected (active_len=0).
